// File: rtl/fc_pkg.sv
// Shared FP32 field constants, default class count and FSM encoding for fc_argmax.
package fc_pkg;

    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam logic [FP_EXP_MSB-FP_EXP_LSB:0] FP_EXP_ONES = '1;

    localparam int N_CLASSES_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic logic fp32_is_nan(input logic [31:0] x);
        return (x[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ONES) && (x[FP_MAN_MSB:0] != '0);
    endfunction

endpackage

// File: rtl/fp32_gt.sv
// Combinational FP32 strict greater-than (a > b) in sign-magnitude form; NaN never wins.
module fp32_gt
    import fc_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        gt_o
);

    logic a_nan;
    logic b_nan;
    logic both_zero;
    logic a_neg;
    logic b_neg;
    logic [FP_SIGN_BIT-1:0] a_mag;
    logic [FP_SIGN_BIT-1:0] b_mag;

    assign a_nan     = fp32_is_nan(a_i);
    assign b_nan     = fp32_is_nan(b_i);
    assign a_neg     = a_i[FP_SIGN_BIT];
    assign b_neg     = b_i[FP_SIGN_BIT];
    assign a_mag     = a_i[FP_SIGN_BIT-1:0];
    assign b_mag     = b_i[FP_SIGN_BIT-1:0];
    assign both_zero = (a_mag == '0) && (b_mag == '0);

    always_comb begin
        gt_o = 1'b0;
        if (a_nan) begin
            gt_o = 1'b0;
        end else if (b_nan) begin
            gt_o = 1'b1;
        end else if (both_zero) begin
            // +0 and -0 compare equal
            gt_o = 1'b0;
        end else if (!a_neg && b_neg) begin
            gt_o = 1'b1;
        end else if (a_neg && !b_neg) begin
            gt_o = 1'b0;
        end else if (!a_neg) begin
            gt_o = (a_mag > b_mag);
        end else begin
            gt_o = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/fc_argmax.sv
// Sequential argmax over an FP32 score vector, one element per clock.
// Optional runner-up tracking is enabled by defining FC_ARGMAX_SECOND_EN.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CLASSES*DATA_W-1:0]   iScores,
    input  logic                          iValid,
    output logic                          oInReady,
    output logic                          oValid,
    input  logic                          iOutReady,
    output logic [IDX_W-1:0]              oClass,
    output logic [DATA_W-1:0]             oMaxScore
`ifdef FC_ARGMAX_SECOND_EN
    ,
    output logic [IDX_W-1:0]              oSecondClass,
    output logic [DATA_W-1:0]             oSecondScore
`endif
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   best_q, best_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   vec_q [N_CLASSES];
    logic [DATA_W-1:0]   elem;
    logic                elem_gt_best;
    logic                accept;
    logic                last;

    assign elem = vec_q[cnt_q];
    assign last = (cnt_q == IDX_W'(N_CLASSES - 1));

    fp32_gt u_gt_best (
        .a_i  (elem),
        .b_i  (best_q),
        .gt_o (elem_gt_best)
    );

`ifdef FC_ARGMAX_SECOND_EN
    logic [DATA_W-1:0]   sec_q, sec_d;
    logic [IDX_W-1:0]    sec_idx_q, sec_idx_d;
    logic                sec_set_q, sec_set_d;
    logic                elem_gt_sec;

    fp32_gt u_gt_sec (
        .a_i  (elem),
        .b_i  (sec_q),
        .gt_o (elem_gt_sec)
    );
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        best_d  = best_q;
        idx_d   = idx_q;
        accept  = 1'b0;
`ifdef FC_ARGMAX_SECOND_EN
        sec_d     = sec_q;
        sec_idx_d = sec_idx_q;
        sec_set_d = sec_set_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    accept  = 1'b1;
                    best_d  = iScores[DATA_W-1:0];
                    idx_d   = '0;
                    cnt_d   = IDX_W'(1);
                    state_d = ST_SCAN;
`ifdef FC_ARGMAX_SECOND_EN
                    sec_d     = '0;
                    sec_idx_d = '0;
                    sec_set_d = 1'b0;
`endif
                end
            end
            ST_SCAN: begin
                if (elem_gt_best) begin
                    best_d = elem;
                    idx_d  = cnt_q;
                end
`ifdef FC_ARGMAX_SECOND_EN
                // Unset or NaN runner-up is displaced by any non-NaN element.
                if (elem_gt_best) begin
                    sec_d     = best_q;
                    sec_idx_d = idx_q;
                    sec_set_d = 1'b1;
                end else if (!fp32_is_nan(elem) && (!sec_set_q || elem_gt_sec)) begin
                    sec_d     = elem;
                    sec_idx_d = cnt_q;
                    sec_set_d = 1'b1;
                end
`endif
                if (last) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_HOLD: begin
                if (iOutReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            best_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
        end
    end

`ifdef FC_ARGMAX_SECOND_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_q     <= '0;
            sec_idx_q <= '0;
            sec_set_q <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            sec_idx_q <= sec_idx_d;
            sec_set_q <= sec_set_d;
        end
    end

    assign oSecondClass = sec_idx_q;
    assign oSecondScore = sec_q;
`endif

    // Vector snapshot: data only, never needs reset since reads are gated by the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N_CLASSES; i++) begin
                vec_q[i] <= iScores[i*DATA_W +: DATA_W];
            end
        end
    end

    assign oInReady  = (state_q == ST_IDLE) && reset;
    assign oValid    = (state_q == ST_HOLD);
    assign oClass    = idx_q;
    assign oMaxScore = best_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax.
module tb_fc_argmax;

    localparam int NC = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic              clk;
    logic              reset;
    logic [NC*DW-1:0]  iScores;
    logic              iValid;
    logic              oInReady;
    logic              oValid;
    logic              iOutReady;
    logic [IW-1:0]     oClass;
    logic [DW-1:0]     oMaxScore;
`ifdef FC_ARGMAX_SECOND_EN
    logic [IW-1:0]     oSecondClass;
    logic [DW-1:0]     oSecondScore;
`endif

    int tests;
    int fails;

    fc_argmax #(.N_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .iScores   (iScores),
        .iValid    (iValid),
        .oInReady  (oInReady),
        .oValid    (oValid),
        .iOutReady (iOutReady),
        .oClass    (oClass),
        .oMaxScore (oMaxScore)
`ifdef FC_ARGMAX_SECOND_EN
        ,
        .oSecondClass (oSecondClass),
        .oSecondScore (oSecondScore)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Accept v, then confirm oValid is low through edge k+8 and high after k+9 with the result.
    task automatic run_vec(input logic [NC*DW-1:0] v, input logic [31:0] ecls,
                           input logic [31:0] escore, input string tag);
        check({tag, "_ready"}, 32'(oInReady), 32'd1);
        iScores = v;
        iValid  = 1'b1;
        tick();
        iValid  = 1'b0;
        iScores = ~v;
        check({tag, "_busy"}, 32'(oInReady), 32'd0);
        repeat (8) tick();
        check({tag, "_vld_early"}, 32'(oValid), 32'd0);
        tick();
        check({tag, "_vld"}, 32'(oValid), 32'd1);
        check({tag, "_cls"}, 32'(oClass), ecls);
        check({tag, "_score"}, oMaxScore, escore);
    endtask

    task automatic release_out(input string tag);
        iOutReady = 1'b1;
        tick();
        iOutReady = 1'b0;
        check({tag, "_rel_vld"}, 32'(oValid), 32'd0);
        check({tag, "_rel_rdy"}, 32'(oInReady), 32'd1);
    endtask

    logic [NC*DW-1:0] v1, v2, v3, v4a, v4b, v5, v6;
    logic [31:0]      negs [NC];

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b0;
        iValid    = 1'b0;
        iOutReady = 1'b0;
        iScores   = '0;

        negs = '{32'hbf800000, 32'hc0000000, 32'hc0400000, 32'hc0800000, 32'hc0a00000,
                 32'hc0c00000, 32'hc0e00000, 32'hc1000000, 32'hc1100000, 32'hc1200000};

        v1 = {NC{32'h3f800000}};
        v1[7*DW +: DW] = 32'h40000000;
        v2 = {NC{32'h3f800000}};
        v2[3*DW +: DW] = 32'h40000000;
        v2[5*DW +: DW] = 32'h40000000;
        for (int i = 0; i < NC; i++) v3[i*DW +: DW] = negs[i];
        v3[4*DW +: DW] = 32'hbf000000;
        v4a = {NC{32'h3f800000}};
        v4a[2*DW +: DW] = 32'h7fc00000;
        v4a[9*DW +: DW] = 32'h7f800000;
        v4b = {NC{32'h7fc00000}};
        v5 = {NC{32'hbf800000}};
        v5[0 +: DW]  = 32'h00000000;
        v5[DW +: DW] = 32'h80000000;
        v6 = {NC{32'hbf800000}};
        v6[0 +: DW]  = 32'h80000000;
        v6[DW +: DW] = 32'h00000000;

        #3;
        check("rst_inready", 32'(oInReady), 32'd0);
        check("rst_valid", 32'(oValid), 32'd0);
        check("rst_class", 32'(oClass), 32'd0);
        check("rst_score", oMaxScore, 32'd0);
        #9 reset = 1'b1;
        #1;
        check("idle_inready", 32'(oInReady), 32'd1);
        tick();

        // Single maximum, then backpressure with an ignored iValid pulse.
        run_vec(v1, 32'd7, 32'h40000000, "t1");
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                iScores = v3;
                iValid  = 1'b1;
            end
            tick();
            iValid = 1'b0;
            check("bp_vld", 32'(oValid), 32'd1);
            check("bp_rdy", 32'(oInReady), 32'd0);
            check("bp_cls", 32'(oClass), 32'd7);
            check("bp_score", oMaxScore, 32'h40000000);
        end
        release_out("t1");

        run_vec(v2, 32'd3, 32'h40000000, "t2_tie");
`ifdef FC_ARGMAX_SECOND_EN
        check("t2_sec_cls", 32'(oSecondClass), 32'd5);
        check("t2_sec_score", oSecondScore, 32'h40000000);
`endif
        release_out("t2");

        run_vec(v3, 32'd4, 32'hbf000000, "t3_neg");
        release_out("t3");

        run_vec(v4a, 32'd9, 32'h7f800000, "t4_inf");
        release_out("t4a");

        run_vec(v4b, 32'd0, 32'h7fc00000, "t4_allnan");
        release_out("t4b");

        run_vec(v5, 32'd0, 32'h00000000, "t5_pzero");
        release_out("t5");

        run_vec(v6, 32'd0, 32'h80000000, "t5_nzero");
        release_out("t5b");

        // Reset in the middle of a scan, after the running best has moved to index 7.
        iScores = v1;
        iValid  = 1'b1;
        tick();
        iValid = 1'b0;
        repeat (8) tick();
        check("mid_cls", 32'(oClass), 32'd7);
        #2 reset = 1'b0;
        #1;
        check("arst_vld", 32'(oValid), 32'd0);
        check("arst_cls", 32'(oClass), 32'd0);
        check("arst_score", oMaxScore, 32'd0);
        check("arst_rdy", 32'(oInReady), 32'd0);
        #10 reset = 1'b1;
        tick();
        run_vec(v3, 32'd4, 32'hbf000000, "t6_after_rst");
        release_out("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
